// File: rtl/reg_spiller.sv
`default_nettype none
// ============================================================================
//  Module      : reg_spiller
//  Description : Spills the whole register stack to memory (save) or refills
//                it from memory (restore). A save reads registers two at a
//                time and writes them to base+0 .. base+N-1. A restore reads
//                base+0 .. base+N-1 and writes each word back into its
//                register.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset_n             clock, synchronous active-low reset
//    save_req, restore_req    operation requests, sampled only in IDLE
//    base_addr                memory address of register 0's slot
//    busy, done               status flag / one-cycle completion pulse
//    rs_num1/2, rs_get_enable register stack read port (data next cycle)
//    rs_out1/2                register stack read data
//    rs_setnum/val/enable     register stack write port
//    mem_addr/wdata           memory request address / write data
//    mem_write, mem_read      memory requests, held until mem_ready
//    mem_rdata, mem_ready     memory read data / accept-complete
// ============================================================================
module reg_spiller #(
  parameter int WORD_SIZE      = 16,
  parameter int NIB_SIZE       = 4,
  parameter int REG_STACK_SIZE = 16   // must be even and equal 2**NIB_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 save_req,
  input  logic                 restore_req,
  input  logic [WORD_SIZE-1:0] base_addr,
  output logic                 busy,
  output logic                 done,
  output logic [NIB_SIZE-1:0]  rs_num1,
  output logic [NIB_SIZE-1:0]  rs_num2,
  output logic                 rs_get_enable,
  input  logic [WORD_SIZE-1:0] rs_out1,
  input  logic [WORD_SIZE-1:0] rs_out2,
  output logic [NIB_SIZE-1:0]  rs_setnum,
  output logic [WORD_SIZE-1:0] rs_setval,
  output logic                 rs_set_enable,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 mem_write,
  output logic                 mem_read,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_GET   = 3'd1,
    S_LATCH = 3'd2,
    S_W0    = 3'd3,
    S_W1    = 3'd4,
    R_RD    = 3'd5,
    R_SET   = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int                  C_PAD       = WORD_SIZE - NIB_SIZE;
  localparam logic [NIB_SIZE-1:0] C_LAST_PAIR = NIB_SIZE'(REG_STACK_SIZE / 2 - 1);
  localparam logic [NIB_SIZE-1:0] C_LAST_REG  = NIB_SIZE'(REG_STACK_SIZE - 1);

  state_t                r_state;
  logic [NIB_SIZE-1:0]   r_idx;     // pair index p during save, register index i during restore
  logic [WORD_SIZE-1:0]  r_base;
  logic [WORD_SIZE-1:0]  r_buf0;
  logic [WORD_SIZE-1:0]  r_buf1;

  logic [NIB_SIZE-1:0]   w_idx_inc;
  logic [NIB_SIZE-1:0]   w_pair_lo;
  logic [NIB_SIZE-1:0]   w_pair_hi;
  logic [NIB_SIZE-1:0]   w_next_lo;
  logic [NIB_SIZE-1:0]   w_next_hi;
  logic [WORD_SIZE-1:0]  w_addr_lo;
  logic [WORD_SIZE-1:0]  w_addr_hi;
  logic [WORD_SIZE-1:0]  w_addr_i;
  logic [WORD_SIZE-1:0]  w_addr_inc;

  // Register numbers of the current and next pair: 2p and 2p+1.
  assign w_idx_inc  = r_idx + NIB_SIZE'(1);
  assign w_pair_lo  = {r_idx[NIB_SIZE-2:0], 1'b0};
  assign w_pair_hi  = {r_idx[NIB_SIZE-2:0], 1'b1};
  assign w_next_lo  = {w_idx_inc[NIB_SIZE-2:0], 1'b0};
  assign w_next_hi  = {w_idx_inc[NIB_SIZE-2:0], 1'b1};

  // Plain WORD_SIZE-bit adds, so slot addresses wrap past the top of memory.
  assign w_addr_lo  = r_base + {{C_PAD{1'b0}}, w_pair_lo};
  assign w_addr_hi  = r_base + {{C_PAD{1'b0}}, w_pair_hi};
  assign w_addr_i   = r_base + {{C_PAD{1'b0}}, r_idx};
  assign w_addr_inc = r_base + {{C_PAD{1'b0}}, w_idx_inc};

  // All outputs are registered: each branch sets the values for the state it
  // moves into. Everything defaults to deasserted/zero, so any state that does
  // not drive a strobe or bus leaves it at 0 and the strobes stay exclusive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_base        <= '0;
      r_buf0        <= '0;
      r_buf1        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rs_num1       <= '0;
      rs_num2       <= '0;
      rs_get_enable <= 1'b0;
      rs_setnum     <= '0;
      rs_setval     <= '0;
      rs_set_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;
    end else begin
      busy          <= 1'b1;
      done          <= 1'b0;
      rs_num1       <= '0;
      rs_num2       <= '0;
      rs_get_enable <= 1'b0;
      rs_setnum     <= '0;
      rs_setval     <= '0;
      rs_set_enable <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_write     <= 1'b0;
      mem_read      <= 1'b0;

      case (r_state)
        IDLE: begin
          busy <= save_req | restore_req;
          if (save_req) begin
            r_state       <= S_GET;
            r_base        <= base_addr;
            r_idx         <= '0;
            rs_get_enable <= 1'b1;
            rs_num1       <= '0;
            rs_num2       <= NIB_SIZE'(1);
          end else if (restore_req) begin
            r_state  <= R_RD;
            r_base   <= base_addr;
            r_idx    <= '0;
            mem_read <= 1'b1;
            mem_addr <= base_addr;
          end
        end

        // Register stack data appears during S_LATCH.
        S_GET: r_state <= S_LATCH;

        S_LATCH: begin
          r_buf0    <= rs_out1;
          r_buf1    <= rs_out2;
          r_state   <= S_W0;
          mem_write <= 1'b1;
          mem_addr  <= w_addr_lo;
          mem_wdata <= rs_out1;
        end

        S_W0: begin
          mem_write <= 1'b1;
          if (mem_ready) begin
            r_state   <= S_W1;
            mem_addr  <= w_addr_hi;
            mem_wdata <= r_buf1;
          end else begin
            mem_addr  <= w_addr_lo;
            mem_wdata <= r_buf0;
          end
        end

        S_W1: begin
          if (mem_ready) begin
            if (r_idx == C_LAST_PAIR) begin
              r_state <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              r_idx         <= w_idx_inc;
              r_state       <= S_GET;
              rs_get_enable <= 1'b1;
              rs_num1       <= w_next_lo;
              rs_num2       <= w_next_hi;
            end
          end else begin
            mem_write <= 1'b1;
            mem_addr  <= w_addr_hi;
            mem_wdata <= r_buf1;
          end
        end

        R_RD: begin
          if (mem_ready) begin
            r_state       <= R_SET;
            rs_set_enable <= 1'b1;
            rs_setnum     <= r_idx;
            rs_setval     <= mem_rdata;
          end else begin
            mem_read <= 1'b1;
            mem_addr <= w_addr_i;
          end
        end

        R_SET: begin
          if (r_idx == C_LAST_REG) begin
            r_state <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_idx    <= w_idx_inc;
            r_state  <= R_RD;
            mem_read <= 1'b1;
            mem_addr <= w_addr_inc;
          end
        end

        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_spiller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_spiller
//  Description : Self-checking bench for reg_spiller. Plays the register
//                stack and the memory, logs every accepted memory write and
//                register write, and compares against the expected slot
//                layout mem[base+k] <-> reg[k].
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_spiller;

  logic        clk = 1'b0;
  logic        reset_n, save_req, restore_req;
  logic [15:0] base_addr;
  logic        busy, done, rs_get_enable, rs_set_enable, mem_write, mem_read, mem_ready;
  logic [3:0]  rs_num1, rs_num2, rs_setnum;
  logic [15:0] rs_out1, rs_out2, rs_setval, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  reg_spiller #(.WORD_SIZE(16), .NIB_SIZE(4), .REG_STACK_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done),
    .rs_num1(rs_num1), .rs_num2(rs_num2), .rs_get_enable(rs_get_enable),
    .rs_out1(rs_out1), .rs_out2(rs_out2),
    .rs_setnum(rs_setnum), .rs_setval(rs_setval), .rs_set_enable(rs_set_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Environment models
  logic [15:0] regs [16];
  logic [15:0] mem  [65536];
  int          ready_mode = 0;   // 0: always ready, 1: 3 wait cycles per request, 2: random
  int          wait_cnt   = 0;
  logic        rnd_ready  = 1'b0;

  assign mem_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (wait_cnt == 3) : rnd_ready;
  assign mem_rdata = mem_read ? mem[mem_addr] : 16'h0000;

  always @(negedge clk) rnd_ready <= 1'($urandom_range(0, 1));

  typedef struct packed { logic [15:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [3:0]  n; logic [15:0] v; } st_t;
  wr_t wlog[$];
  st_t slog[$];

  int   cyc = 0, done_cnt = 0, done_cyc = 0, rd_cnt = 0;
  int   excl_err = 0, stab_err = 0, zero_err = 0;
  bit   mon_en = 0;
  logic prev_pend = 1'b0, prev_w = 1'b0;
  logic [15:0] prev_a = '0, prev_d = '0;
  int   n_pass = 0, n_total = 0, req_cyc = 0;

  // Register stack read port and bus monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rs_get_enable) begin
      rs_out1 <= regs[rs_num1];
      rs_out2 <= regs[rs_num2];
    end else begin
      rs_out1 <= 16'hDEAD;
      rs_out2 <= 16'hBEEF;
    end
    if (!reset_n) wait_cnt <= 0;
    else if ((mem_write || mem_read) && !mem_ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    prev_pend <= 1'b0;
    if (mon_en && reset_n) begin
      if (mem_write && mem_ready) wlog.push_back({mem_addr, mem_wdata});
      if (mem_read && mem_ready) rd_cnt <= rd_cnt + 1;
      if (rs_set_enable) slog.push_back({rs_setnum, rs_setval});
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
      end
      if (int'(rs_get_enable) + int'(rs_set_enable) + int'(mem_write) + int'(mem_read) > 1)
        excl_err <= excl_err + 1;
      if ((!mem_write && mem_wdata !== 16'h0) || (!mem_write && !mem_read && mem_addr !== 16'h0))
        zero_err <= zero_err + 1;
      if (prev_pend && (mem_write !== prev_w || mem_read !== !prev_w ||
                        mem_addr !== prev_a || mem_wdata !== prev_d))
        stab_err <= stab_err + 1;
      prev_pend <= (mem_write || mem_read) && !mem_ready;
      prev_w    <= mem_write;
      prev_a    <= mem_addr;
      prev_d    <= mem_wdata;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_req(input bit s, input bit r, input logic [15:0] b);
    @(negedge clk);
    save_req = s; restore_req = r; base_addr = b;
    @(negedge clk);
    save_req = 0; restore_req = 0; base_addr = 16'($urandom);
    req_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int start;
    start = done_cnt;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != start) begin ok = 1; break; end
    end
  endtask

  task automatic fill_regs_random();
    for (int k = 0; k < 16; k++) regs[k] = 16'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 0; save_req = 0; restore_req = 0; base_addr = 16'h0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, rs_get_enable, rs_set_enable, mem_write, mem_read} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {busy, done, rs_get_enable, rs_set_enable, mem_write, mem_read});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata, rs_setval} !== 48'h0)
      $display("FAIL reset_buses: got addr=%h wdata=%h setval=%h expected 0", mem_addr, mem_wdata, rs_setval);
    else n_pass++;
    n_total++;
    if ({rs_num1, rs_num2, rs_setnum} !== 12'h0)
      $display("FAIL reset_indices: got %h %h %h expected 0", rs_num1, rs_num2, rs_setnum);
    else n_pass++;
    reset_n = 1; mon_en = 1;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_save_basic();
    bit ok; int d0;
    logic [15:0] ea;
    for (int k = 0; k < 16; k++) regs[k] = 16'h1000 + 16'(k);
    ready_mode = 0; wlog.delete(); d0 = done_cnt;
    pulse_req(1, 0, 16'h0100);
    wait_done(200, ok);
    n_total++;
    if (!ok) $display("FAIL save_basic_timeout: got no done expected done"); else n_pass++;
    n_total++;
    if (done_cyc - req_cyc !== 33)
      $display("FAIL save_latency: got %0d expected 33", done_cyc - req_cyc);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL save_done_pulses: got %0d expected 1", done_cnt - d0);
    else n_pass++;
    n_total++;
    if (wlog.size() !== 16) $display("FAIL save_write_count: got %0d expected 16", wlog.size());
    else n_pass++;
    for (int k = 0; k < 16 && k < wlog.size(); k++) begin
      ea = 16'h0100 + 16'(k);
      n_total++;
      if (wlog[k] !== {ea, 16'h1000 + 16'(k)})
        $display("FAIL save_word[%0d]: got %h:%h expected %h:%h", k, wlog[k].a, wlog[k].d, ea, 16'h1000 + 16'(k));
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL save_busy_after: got %b expected 0", busy); else n_pass++;
  endtask

  task automatic test_restore();
    bit ok; int r0, bad;
    for (int k = 0; k < 16; k++) mem[16'h0200 + 16'(k)] = 16'hA000 + 16'(k);
    ready_mode = 0; slog.delete(); wlog.delete(); r0 = rd_cnt;
    pulse_req(0, 1, 16'h0200);
    wait_done(200, ok);
    n_total++;
    if (!ok) $display("FAIL restore_timeout: got no done expected done"); else n_pass++;
    n_total++;
    if (done_cyc - req_cyc !== 33)
      $display("FAIL restore_latency: got %0d expected 33", done_cyc - req_cyc);
    else n_pass++;
    n_total++;
    if (slog.size() !== 16 || rd_cnt - r0 !== 16 || wlog.size() !== 0)
      $display("FAIL restore_counts: got sets=%0d reads=%0d writes=%0d expected 16/16/0",
               slog.size(), rd_cnt - r0, wlog.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 16 && k < slog.size(); k++)
      if (slog[k] !== {4'(k), 16'hA000 + 16'(k)}) bad++;
    n_total++;
    if (bad !== 0) $display("FAIL restore_data: got %0d wrong register writes expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_stall_save();
    bit ok; int s0, bad;
    logic [15:0] b;
    fill_regs_random();
    b = 16'($urandom); ready_mode = 1; wlog.delete(); s0 = stab_err;
    pulse_req(1, 0, b);
    wait_done(500, ok);
    n_total++;
    if (!ok) $display("FAIL stall_timeout: got no done expected done"); else n_pass++;
    // 8 pairs x (get + latch + 2 writes x 4 cycles) + done
    n_total++;
    if (done_cyc - req_cyc !== 81)
      $display("FAIL stall_latency: got %0d expected 81", done_cyc - req_cyc);
    else n_pass++;
    n_total++;
    if (wlog.size() !== 16) $display("FAIL stall_write_count: got %0d expected 16", wlog.size());
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      if (wlog[k] !== {16'(b + 16'(k)), regs[k]}) bad++;
    n_total++;
    if (bad !== 0) $display("FAIL stall_data: got %0d wrong words expected 0", bad); else n_pass++;
    n_total++;
    if (stab_err !== s0) $display("FAIL stall_stability: got %0d unstable cycles expected 0", stab_err - s0);
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_priority();
    bit seen; int r0, d0;
    fill_regs_random();
    ready_mode = 0; wlog.delete(); slog.delete(); r0 = rd_cnt; d0 = done_cnt;
    pulse_req(1, 1, 16'h0400);
    repeat (5) @(negedge clk);
    restore_req = 1;
    @(negedge clk);
    restore_req = 0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    restore_req = 1;          // presented during DONE, must be ignored
    @(negedge clk);
    restore_req = 0;
    repeat (40) @(negedge clk);
    n_total++;
    if (!seen) $display("FAIL prio_timeout: got no done expected done"); else n_pass++;
    n_total++;
    if (wlog.size() !== 16 || slog.size() !== 0 || rd_cnt !== r0)
      $display("FAIL prio_save_wins: got writes=%0d sets=%0d reads=%0d expected 16/0/0",
               wlog.size(), slog.size(), rd_cnt - r0);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0)
      $display("FAIL prio_single_op: got done=%0d busy=%b expected 1/0", done_cnt - d0, busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok; int bad;
    fill_regs_random();
    ready_mode = 0; wlog.delete();
    pulse_req(1, 0, 16'hFFFE);
    wait_done(200, ok);
    bad = 0;
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      if (wlog[k] !== {16'(16'hFFFE + 16'(k)), regs[k]}) bad++;
    n_total++;
    if (!ok || wlog.size() !== 16 || bad !== 0)
      $display("FAIL wrap: got done=%b writes=%0d bad=%0d expected 1/16/0", ok, wlog.size(), bad);
    else n_pass++;
    n_total++;
    if (wlog.size() > 2 && wlog[2].a !== 16'h0000)
      $display("FAIL wrap_third_addr: got %h expected 0000", wlog[2].a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit found, ok; int d0, bad;
    logic [15:0] b;
    fill_regs_random();
    b = 16'h3000; ready_mode = 1;
    pulse_req(1, 0, b);
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_write === 1'b1 && mem_addr === 16'h3006) begin found = 1; break; end
    end
    n_total++;
    if (!found) $display("FAIL midreset_reach_w0: got not reached expected pair 3 write"); else n_pass++;
    reset_n = 0; d0 = done_cnt;
    @(negedge clk);
    n_total++;
    if ({busy, done, rs_get_enable, rs_set_enable, mem_write, mem_read} !== 6'b0 ||
        {mem_addr, mem_wdata, rs_setval} !== 48'h0)
      $display("FAIL midreset_outputs: got flags=%b addr=%h wdata=%h expected 0",
               {busy, done, rs_get_enable, rs_set_enable, mem_write, mem_read}, mem_addr, mem_wdata);
    else n_pass++;
    reset_n = 1;
    repeat (60) @(negedge clk);
    n_total++;
    if (done_cnt !== d0 || busy !== 1'b0)
      $display("FAIL midreset_no_done: got done=%0d busy=%b expected 0/0", done_cnt - d0, busy);
    else n_pass++;
    fill_regs_random();
    ready_mode = 2; wlog.delete();
    pulse_req(1, 0, 16'h0050);
    wait_done(2000, ok);
    bad = 0;
    for (int k = 0; k < 16 && k < wlog.size(); k++)
      if (wlog[k] !== {16'h0050 + 16'(k), regs[k]}) bad++;
    n_total++;
    if (!ok || wlog.size() !== 16 || bad !== 0)
      $display("FAIL midreset_resave: got done=%b writes=%0d bad=%0d expected 1/16/0", ok, wlog.size(), bad);
    else n_pass++;
    ready_mode = 0;
  endtask

  task automatic test_random_ops();
    bit ok, is_save; int bad;
    logic [15:0] b;
    for (int it = 0; it < 8; it++) begin
      is_save = 1'($urandom_range(0, 1));
      ready_mode = $urandom_range(0, 2);
      b = 16'($urandom);
      wlog.delete(); slog.delete();
      if (is_save) fill_regs_random();
      else for (int k = 0; k < 16; k++) mem[16'(b + 16'(k))] = 16'($urandom);
      pulse_req(is_save, !is_save, b);
      wait_done(2000, ok);
      bad = 0;
      if (is_save) begin
        if (wlog.size() !== 16 || slog.size() !== 0) bad++;
        for (int k = 0; k < 16 && k < wlog.size(); k++)
          if (wlog[k] !== {16'(b + 16'(k)), regs[k]}) bad++;
      end else begin
        if (slog.size() !== 16 || wlog.size() !== 0) bad++;
        for (int k = 0; k < 16 && k < slog.size(); k++)
          if (slog[k] !== {4'(k), mem[16'(b + 16'(k))]}) bad++;
      end
      n_total++;
      if (!ok || bad !== 0)
        $display("FAIL random_op[%0d] save=%b mode=%0d: got done=%b bad=%0d expected 1/0",
                 it, is_save, ready_mode, ok, bad);
      else n_pass++;
    end
    ready_mode = 0;
  endtask

  task automatic test_invariants();
    n_total++;
    if (excl_err !== 0) $display("FAIL strobe_exclusive: got %0d violations expected 0", excl_err);
    else n_pass++;
    n_total++;
    if (zero_err !== 0) $display("FAIL idle_bus_zero: got %0d violations expected 0", zero_err);
    else n_pass++;
    n_total++;
    if (stab_err !== 0) $display("FAIL wait_stability: got %0d violations expected 0", stab_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_save_basic();
    test_restore();
    test_stall_save();
    test_priority();
    test_wrap();
    test_reset_mid();
    test_random_ops();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
